// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// cause codes, SYSTEM-instruction encodings, FSM states and mstatus helpers.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
  localparam logic [31:0] CAUSE_ECALL     = 32'd11;
  localparam logic [31:0] CAUSE_M_EXT_IRQ = 32'h8000_000B;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_STATUS,
    T_JUMP,
    R_STATUS,
    R_JUMP
  } trap_state_e;

  // Trap entry: stash MIE into MPIE and disable interrupts.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
    logic [31:0] r;
    r               = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
    logic [31:0] r;
    r               = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_classify.sv
// Combinational event classifier for the instruction in flight.
// Priority: illegal > ecall/ebreak > mret > external interrupt.
// Macro TRAP_IRQ_EN: when defined the external interrupt can raise a trap,
// otherwise irq_i is ignored.
module trap_classify
  import trap_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic        illegal_i,
  input  logic        irq_i,
  input  logic        mie_i,
  output logic        is_trap_o,
  output logic        is_mret_o,
  output logic [31:0] cause_o
);

  logic irq_take;

`ifdef TRAP_IRQ_EN
  assign irq_take = irq_i & mie_i;
`else
  logic unused_irq;
  assign unused_irq = irq_i & mie_i;
  assign irq_take   = 1'b0;
`endif

  // Pick the highest-priority event; synchronous exceptions beat the irq.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    is_trap_o = 1'b0;
    is_mret_o = 1'b0;
    cause_o   = '0;
    if (illegal_i) begin
      is_trap_o = 1'b1;
      cause_o   = CAUSE_ILLEGAL;
    end else if (instr_i == INSTR_ECALL) begin
      is_trap_o = 1'b1;
      cause_o   = CAUSE_ECALL;
    end else if (instr_i == INSTR_EBREAK) begin
      is_trap_o = 1'b1;
      cause_o   = CAUSE_EBREAK;
    end else if (instr_i == INSTR_MRET) begin
      is_mret_o = 1'b1;
    end else if (irq_take) begin
      is_trap_o = 1'b1;
      cause_o   = CAUSE_M_EXT_IRQ;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. Owns the CSR write port and PC redirect for
// the fixed trap-entry (mepc, mcause, mstatus, jump) and mret (mstatus, jump)
// sequences while stalling the datapath.
// Macro TRAP_IRQ_EN: enables the external interrupt as a trap source.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic            illegal_i,
  input  logic            irq_i,
  input  logic [31:0]     mstatus_i,
  input  logic [31:0]     mtvec_i,
  input  logic [31:0]     mepc_i,
  output logic            kill_o,
  output logic            stall_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_addr_o,
  output logic [31:0]     csr_wdata_o,
  output logic            pc_redirect_o,
  output logic [PC_W-1:0] pc_target_o,
  output logic            busy_o
);

  trap_state_e     state_q, state_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic [31:0]     cause_q, cause_d;

  logic            cls_trap, cls_mret;
  logic [31:0]     cls_cause;
  logic            event_hit;

  // Only the low PC_W bits of mtvec/mepc form a target; the rest is unused.
  logic unused_bits;
  assign unused_bits = ^{mtvec_i, mepc_i};

  trap_classify u_classify (
    .instr_i   (instr_i),
    .illegal_i (illegal_i),
    .irq_i     (irq_i),
    .mie_i     (mstatus_i[MSTATUS_MIE]),
    .is_trap_o (cls_trap),
    .is_mret_o (cls_mret),
    .cause_o   (cls_cause)
  );

  // Reset is folded in so kill/stall stay low while rst_n is held.
  assign event_hit = rst_n && (state_q == IDLE) && instr_valid_i &&
                     (cls_trap || cls_mret);

  // State, saved epc and cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and output decode; one CSR write or redirect per state.
  always_comb begin
    state_d       = state_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    kill_o        = 1'b0;
    stall_o       = 1'b0;
    csr_we_o      = 1'b0;
    csr_addr_o    = '0;
    csr_wdata_o   = '0;
    pc_redirect_o = 1'b0;
    pc_target_o   = '0;
    busy_o        = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (event_hit) begin
          kill_o  = 1'b1;
          stall_o = 1'b1;
          epc_d   = pc_i;
          cause_d = cls_cause;
          state_d = cls_trap ? T_EPC : R_STATUS;
        end
      end
      T_EPC: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_MEPC;
        csr_wdata_o = {{(32-PC_W){1'b0}}, epc_q};
        state_d     = T_CAUSE;
      end
      T_CAUSE: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_MCAUSE;
        csr_wdata_o = cause_q;
        state_d     = T_STATUS;
      end
      T_STATUS: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_MSTATUS;
        csr_wdata_o = mstatus_on_trap(mstatus_i);
        state_d     = T_JUMP;
      end
      T_JUMP: begin
        stall_o       = 1'b1;
        pc_redirect_o = 1'b1;
        pc_target_o   = {mtvec_i[PC_W-1:2], 2'b00};
        state_d       = IDLE;
      end
      R_STATUS: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_MSTATUS;
        csr_wdata_o = mstatus_on_mret(mstatus_i);
        state_d     = R_JUMP;
      end
      R_JUMP: begin
        stall_o       = 1'b1;
        pc_redirect_o = 1'b1;
        pc_target_o   = {mepc_i[PC_W-1:2], 2'b00};
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a step-list model.
module tb_trap_ctrl;

  localparam int PC_W = 16;
`ifdef TRAP_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            instr_valid = 1'b0;
  logic [31:0]     instr = '0;
  logic [PC_W-1:0] pc = '0;
  logic            illegal = 1'b0;
  logic            irq = 1'b0;
  logic [31:0]     mstatus = '0;
  logic [31:0]     mtvec = 32'h0000_0100;
  logic [31:0]     mepc = 32'h0000_0014;

  logic            kill_o, stall_o, csr_we_o, pc_redirect_o, busy_o;
  logic [11:0]     csr_addr_o;
  logic [31:0]     csr_wdata_o;
  logic [PC_W-1:0] pc_target_o;

  trap_ctrl #(.PC_W(PC_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_i (instr_valid),
    .instr_i       (instr),
    .pc_i          (pc),
    .illegal_i     (illegal),
    .irq_i         (irq),
    .mstatus_i     (mstatus),
    .mtvec_i       (mtvec),
    .mepc_i        (mepc),
    .kill_o        (kill_o),
    .stall_o       (stall_o),
    .csr_we_o      (csr_we_o),
    .csr_addr_o    (csr_addr_o),
    .csr_wdata_o   (csr_wdata_o),
    .pc_redirect_o (pc_redirect_o),
    .pc_target_o   (pc_target_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            kill;
    logic            stall;
    logic            we;
    logic [11:0]     addr;
    logic [31:0]     wdata;
    logic            redir;
    logic [PC_W-1:0] target;
    logic            busy;
  } obs_t;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  obs_t last_obs;

  task automatic check_val(input string name, input logic [64:0] act, input logic [64:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The pending work after an event is a list of steps still to perform;
  // each cycle the head step dictates the outputs.
  typedef enum {S_EPC, S_CAUSE, S_TSTAT, S_TJUMP, S_RSTAT, S_RJUMP} step_e;
  step_e       plan[$];
  logic [31:0] m_epc = '0;
  logic [31:0] m_cause = '0;

  function automatic void classify(output bit trap, output bit ret, output logic [31:0] cause);
    trap = 1'b0; ret = 1'b0; cause = '0;
    if (!instr_valid) return;
    if (illegal)                 begin trap = 1'b1; cause = 2;  end
    else if (instr == ECALL)     begin trap = 1'b1; cause = 11; end
    else if (instr == EBREAK)    begin trap = 1'b1; cause = 3;  end
    else if (instr == MRET)      ret = 1'b1;
    else if (IRQ_EN && irq && mstatus[3]) begin trap = 1'b1; cause = 32'h8000_000B; end
  endfunction

  function automatic obs_t model_exp();
    obs_t        e;
    bit          t, r;
    logic [31:0] c;
    e = '0;
    if (!rst_n) return e;
    if (plan.size() == 0) begin
      classify(t, r, c);
      e.kill  = t | r;
      e.stall = t | r;
    end else begin
      e.stall = 1'b1;
      e.busy  = 1'b1;
      case (plan[0])
        S_EPC:   begin e.we = 1'b1; e.addr = 12'h341; e.wdata = m_epc; end
        S_CAUSE: begin e.we = 1'b1; e.addr = 12'h342; e.wdata = m_cause; end
        S_TSTAT: begin e.we = 1'b1; e.addr = 12'h300;
                       e.wdata = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0); end
        S_RSTAT: begin e.we = 1'b1; e.addr = 12'h300;
                       e.wdata = (mstatus & ~32'h88) | 32'h80 | (mstatus[7] ? 32'h8 : 32'h0); end
        S_TJUMP: begin e.redir = 1'b1; e.target = mtvec[PC_W-1:0] & ~16'h3; end
        S_RJUMP: begin e.redir = 1'b1; e.target = mepc[PC_W-1:0] & ~16'h3; end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  task automatic model_step();
    bit          t, r;
    logic [31:0] c;
    step_e       dummy;
    if (!rst_n) begin
      plan.delete();
      m_epc = '0;
      m_cause = '0;
      return;
    end
    if (plan.size() != 0) begin
      dummy = plan.pop_front();
      return;
    end
    classify(t, r, c);
    if (t) begin
      m_epc = 32'(pc); m_cause = c;
      plan = '{S_EPC, S_CAUSE, S_TSTAT, S_TJUMP};
    end else if (r) begin
      m_epc = 32'(pc); m_cause = c;
      plan = '{S_RSTAT, S_RJUMP};
    end
  endtask

  // One clock: sample at the falling edge, compare to the model, advance it,
  // and return just after the next rising edge so the caller can drive.
  task automatic cycle(input string name);
    obs_t exp;
    @(negedge clk);
    last_obs = '{kill_o, stall_o, csr_we_o, csr_addr_o, csr_wdata_o,
                 pc_redirect_o, pc_target_o, busy_o};
    exp = model_exp();
    check_val(name, last_obs, exp);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic ill,
                       input logic rq, input logic [31:0] ms, input logic [PC_W-1:0] p);
    instr_valid = v; instr = ins; illegal = ill; irq = rq; mstatus = ms; pc = p;
  endtask

  task automatic idle_cycles(input int n);
    instr_valid = 1'b0; illegal = 1'b0; irq = 1'b0;
    for (int i = 0; i < n; i++) cycle("drain");
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic            illegal;
    logic            irq;
    logic [31:0]     mstatus;
    logic [PC_W-1:0] pc;
    logic            exp_kill;   // event detected in D
    logic [11:0]     exp_addr1;  // CSR address written in D+1
    logic [31:0]     exp_data2;  // CSR data in D+2 (mcause for a trap)
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, ECALL,         1'b0, 1'b0, 32'h0, 16'h0020, 1'b1, 12'h341, 32'd11};
    tbl[1]  = '{1'b1, EBREAK,        1'b0, 1'b0, 32'h0, 16'h0024, 1'b1, 12'h341, 32'd3};
    tbl[2]  = '{1'b1, MRET,          1'b0, 1'b0, 32'h0, 16'h0028, 1'b1, 12'h300, 32'd0};
    tbl[3]  = '{1'b1, MRET,          1'b1, 1'b0, 32'h0, 16'h002C, 1'b1, 12'h341, 32'd2};
    tbl[4]  = '{1'b1, ECALL,         1'b1, 1'b1, 32'h8, 16'h0030, 1'b1, 12'h341, 32'd2};
    tbl[5]  = '{1'b1, NOP,           1'b0, 1'b0, 32'h8, 16'h0034, 1'b0, 12'h000, 32'd0};
    tbl[6]  = '{1'b0, ECALL,         1'b1, 1'b1, 32'h8, 16'h0038, 1'b0, 12'h000, 32'd0};
    tbl[7]  = '{1'b1, EBREAK,        1'b0, 1'b1, 32'h8, 16'h003C, 1'b1, 12'h341, 32'd3};
    tbl[8]  = '{1'b1, MRET,          1'b0, 1'b1, 32'h8, 16'h0040, 1'b1, 12'h300, 32'd0};
    tbl[9]  = '{1'b1, NOP,           1'b0, 1'b1, 32'h8, 16'h0044, IRQ_EN,
                IRQ_EN ? 12'h341 : 12'h000, IRQ_EN ? 32'h8000_000B : 32'h0};
    tbl[10] = '{1'b1, 32'h0000_0074, 1'b0, 1'b0, 32'h0, 16'h0048, 1'b0, 12'h000, 32'd0};
  end

  // ---------------- test sequence ----------------
  initial begin
    @(posedge clk);
    #1;

    // Reset held with a pending interrupt and a valid ecall: everything 0.
    rst_n = 1'b0;
    drive(1'b1, ECALL, 1'b0, 1'b1, 32'h8, 16'h0010);
    cycle("reset");
    check_val("reset outputs zero", last_obs, '0);
    rst_n = 1'b1;
    idle_cycles(1);

    // Table: detect cycle, D+1 address, D+2 data.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].valid, tbl[i].instr, tbl[i].illegal, tbl[i].irq, tbl[i].mstatus, tbl[i].pc);
      cycle("tbl D");
      check_val($sformatf("tbl[%0d] kill", i), 65'(last_obs.kill), 65'(tbl[i].exp_kill));
      instr_valid = 1'b0; illegal = 1'b0; irq = 1'b0;
      cycle("tbl D+1");
      check_val($sformatf("tbl[%0d] addr D+1", i), 65'(last_obs.addr), 65'(tbl[i].exp_addr1));
      cycle("tbl D+2");
      check_val($sformatf("tbl[%0d] data D+2", i), 65'(last_obs.wdata), 65'(tbl[i].exp_data2));
      idle_cycles(3);
    end

    // Full ecall sequence with spec constants.
    mtvec = 32'h0000_0100;
    drive(1'b1, ECALL, 1'b0, 1'b0, 32'h08, 16'h0010);
    cycle("ecall D");
    check_val("ecall D kill/stall", {last_obs.kill, last_obs.stall, last_obs.busy}, 65'b110);
    instr_valid = 1'b0;
    cycle("ecall D+1");
    check_val("ecall D+1 mepc", {last_obs.kill, last_obs.we, last_obs.addr, last_obs.wdata},
              {1'b0, 1'b1, 12'h341, 32'h10});
    cycle("ecall D+2");
    check_val("ecall D+2 mcause", {last_obs.we, last_obs.addr, last_obs.wdata}, {1'b1, 12'h342, 32'd11});
    cycle("ecall D+3");
    check_val("ecall D+3 mstatus", {last_obs.we, last_obs.addr, last_obs.wdata}, {1'b1, 12'h300, 32'h80});
    cycle("ecall D+4");
    check_val("ecall D+4 redirect", {last_obs.we, last_obs.redir, last_obs.target, last_obs.stall},
              {1'b0, 1'b1, 16'h0100, 1'b1});
    cycle("ecall D+5");
    check_val("ecall D+5 idle", {last_obs.busy, last_obs.stall}, 65'b00);

    // mret: mstatus 0x80 -> 0x88, return to mepc.
    mepc = 32'h0000_0014;
    drive(1'b1, MRET, 1'b0, 1'b0, 32'h80, 16'h0200);
    cycle("mret D");
    instr_valid = 1'b0;
    cycle("mret D+1");
    check_val("mret D+1 mstatus", {last_obs.we, last_obs.addr, last_obs.wdata}, {1'b1, 12'h300, 32'h88});
    cycle("mret D+2");
    check_val("mret D+2 redirect", {last_obs.redir, last_obs.target}, {1'b1, 16'h0014});
    cycle("mret D+3");
    check_val("mret D+3 busy", 65'(last_obs.busy), 65'(0));

    // irq masked, then enabled.
    drive(1'b1, NOP, 1'b0, 1'b1, 32'h0, 16'h0300);
    cycle("irq masked");
    check_val("irq MIE=0 no event", 65'(last_obs.kill), 65'(0));
    mstatus = 32'h8;
    cycle("irq enabled");
    check_val("irq MIE=1 kill", 65'(last_obs.kill), 65'(IRQ_EN));
    instr_valid = 1'b0; irq = 1'b0;
    cycle("irq D+1");
    cycle("irq D+2");
    check_val("irq D+2 cause", 65'(last_obs.wdata), 65'(IRQ_EN ? 32'h8000_000B : 32'h0));
    idle_cycles(3);

    // Pending irq is taken only once mret restores MIE.
    drive(1'b1, NOP, 1'b0, 1'b1, 32'h80, 16'h0400);
    cycle("irq pend masked");
    check_val("irq pending MIE=0", 65'(last_obs.kill), 65'(0));
    instr = MRET;
    cycle("mret beats irq D");
    instr_valid = 1'b0;
    cycle("mret beats irq D+1");
    check_val("mret beats irq addr", 65'(last_obs.addr), 65'(12'h300));
    mstatus = 32'h88;
    cycle("mret beats irq D+2");
    drive(1'b1, NOP, 1'b0, 1'b1, 32'h88, 16'h0404);
    cycle("irq after mret");
    check_val("irq after mret kill", 65'(last_obs.kill), 65'(IRQ_EN));
    idle_cycles(5);

    // Reset pulsed during T_CAUSE.
    drive(1'b1, ECALL, 1'b0, 1'b0, 32'h08, 16'h0500);
    cycle("rst D");
    instr_valid = 1'b0;
    cycle("rst D+1");
    rst_n = 1'b0;
    cycle("rst in T_CAUSE");
    check_val("rst mid-seq outputs", last_obs, '0);
    rst_n = 1'b1;
    cycle("rst after");
    check_val("rst after idle", {last_obs.busy, last_obs.stall, last_obs.redir}, 65'b000);
    cycle("rst after 2");
    check_val("rst no redirect", {last_obs.busy, last_obs.redir}, 65'b00);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      case ($urandom_range(0, 4))
        0: ins = ECALL;
        1: ins = EBREAK;
        2: ins = MRET;
        default: ins = $urandom;
      endcase
      rst_n       = ($urandom_range(0, 199) != 0);
      instr_valid = ($urandom_range(0, 9) < 7);
      instr       = ins;
      illegal     = ($urandom_range(0, 7) == 0);
      irq         = $urandom_range(0, 1) == 1;
      mstatus     = $urandom;
      mtvec       = $urandom;
      mepc        = $urandom;
      pc          = PC_W'($urandom);
      cycle("random");
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer for the rv32i core. It detects exceptions (illegal, ecall, ebreak), an optional external interrupt, and mret on the instruction in flight. It then owns the single CSR write port for a fixed multi-cycle sequence that saves or restores mepc, mcause and mstatus and redirects the PC. It sits beside the main control decoder and muxes its CSR writes and PC redirect over the decoder's `csr_w` path and `jump` path while stalling the datapath.

## Interface
- PC_W, 16, PC width (matches datapath `pc`)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid_i  in  1  instr_i/pc_i hold a valid instruction this cycle
- instr_i  in  32  current instruction
- pc_i  in  PC_W  PC of instr_i
- illegal_i  in  1  main decoder flags instr_i as illegal
- irq_i  in  1  machine external interrupt request, level
- mstatus_i  in  32  current mstatus from CSR file
- mtvec_i  in  32  current mtvec
- mepc_i  in  32  current mepc
- kill_o  out  1  suppress regWrite/memWrite/csr_w of instr_i
- stall_o  out  1  hold PC, block decoder writes
- csr_we_o  out  1  CSR write strobe, has priority over the decoder `csr_w`
- csr_addr_o  out  12  CSR write address
- csr_wdata_o  out  32  CSR write data
- pc_redirect_o  out  1  load pc_target_o into the PC at the next edge
- pc_target_o  out  PC_W  redirect target
- busy_o  out  1  FSM not in IDLE

## Operation
- Classification is combinational, evaluated only in IDLE when instr_valid_i=1:
  - illegal_i=1: cause 2.
  - 0x00000073 (ecall): cause 11.
  - 0x00100073 (ebreak): cause 3.
  - 0x30200073: mret.
  - irq_i=1 with mstatus_i[3]=1: cause 0x8000000B.
- Priority: illegal > ecall/ebreak > mret > irq. A synchronous exception always beats a pending irq in the same cycle.
- On an event in IDLE:
  - kill_o=1 and stall_o=1 combinationally in that cycle.
  - The controller latches epc=pc_i and the cause.
  - Next state: T_EPC for a trap, R_STATUS for mret.
- Trap path, one CSR write per state:
  - T_EPC: addr 0x341, data zero-extended epc.
  - T_CAUSE: addr 0x342, data cause.
  - T_STATUS: addr 0x300, data mstatus_i with bit7←bit3, bit3←0.
  - T_JUMP: pc_redirect_o=1, pc_target_o={mtvec_i[PC_W-1:2],2'b00}. Direct mode only; mtvec_i[1:0] is ignored. Then IDLE.
- mret path:
  - R_STATUS: addr 0x300, data mstatus_i with bit3←bit7, bit7←1.
  - R_JUMP: pc_redirect_o=1, pc_target_o=mepc_i[PC_W-1:0] with bits [1:0] forced to 0. Then IDLE.
- Outside IDLE, instr_valid_i, illegal_i and irq_i are ignored. No nesting.
- A still-asserted irq is taken only after mret restores MIE.

## Timing
- Reset: state IDLE; latched epc/cause = 0; all outputs 0.
- Trap: detect cycle D, then T_EPC (D+1), T_CAUSE (D+2), T_STATUS (D+3), T_JUMP (D+4). The handler's first instruction is at pc_i in D+5.
- mret: D, R_STATUS (D+1), R_JUMP (D+2). The return instruction is at pc_i in D+3.
- stall_o is high from D through the JUMP state inclusive. kill_o is high in D only.
- csr_we_o is high exactly in T_EPC/T_CAUSE/T_STATUS/R_STATUS. In all other states csr_addr_o and csr_wdata_o are 0.
- T_STATUS samples mstatus_i live. The CSR file must not be written by anything else during busy_o.
- rst_n low mid-sequence: immediate return to IDLE, outputs 0. Partially written CSRs are not restored.

## Configuration
- TRAP_IRQ_EN defined: irq_i participates in classification as above.
- TRAP_IRQ_EN undefined: the irq_i port exists but is ignored. No interrupt cause is ever generated, and the mstatus handling is otherwise unchanged.

## Structure
- Shared package trap_pkg holds:
  - CSR addresses (0x300, 0x341, 0x342, 0x305).
  - Cause constants.
  - Encodings for ecall, ebreak and mret.
  - State enum: IDLE, T_EPC, T_CAUSE, T_STATUS, T_JUMP, R_STATUS, R_JUMP.
  - mstatus bit indices MIE=3, MPIE=7.
- Sub-module trap_classify (combinational) takes instr_i, illegal_i, irq_i, mstatus_i[3] and produces is_trap, is_mret and cause. The FSM lives in trap_ctrl.

## Test plan
- Reset: rst_n=0 with irq_i=1 → all outputs 0, busy_o=0.
- ecall (0x00000073) at pc=0x0010, mstatus=0x08, mtvec=0x0100:
  - D+1: write 0x341←0x10.
  - D+2: write 0x342←11.
  - D+3: write 0x300←0x80.
  - D+4: redirect to 0x0100.
  - kill_o=1 only at D.
- Same cycle illegal_i=1 and irq_i=1 (MIE=1) → cause 2, not 0x8000000B.
- mret with mstatus=0x80, mepc=0x0014 → D+1 write 0x300←0x88; D+2 redirect to 0x0014; busy_o low at D+3.
- irq_i=1 with MIE=0 → no event. Then MIE=1 → trap with cause 0x8000000B. Build without TRAP_IRQ_EN → never taken.
- rst_n pulsed low during T_CAUSE → FSM back in IDLE, no redirect, stall_o=0.
